// File: rtl/ejsv32_pkg.sv
// ejsv32_pkg: shared loader FSM state and load-mode encodings.
package ejsv32_pkg;
  typedef enum logic [2:0] {IDLE, LOAD, FLUSH, TERM, PREF, DONE} loader_st_e;
  localparam logic LD_DICT = 1'b0;
  localparam logic LD_TIB = 1'b1;
endpackage

// File: rtl/byte_packer.sv
// byte_packer: inserts one byte into a lane of a DSZ-wide pack word.
// Ports: i_data/i_be current pack word and lane enables, i_lane target lane,
//        i_byte incoming byte, i_en insert strobe; o_data/o_be updated word
//        and enables, o_full set when the top lane is being filled.
module byte_packer #(
  parameter int DSZ = 8
) (
  input  logic [DSZ-1:0]   i_data,
  input  logic [DSZ/8-1:0] i_be,
  input  logic [1:0]       i_lane,
  input  logic [7:0]       i_byte,
  input  logic             i_en,
  output logic [DSZ-1:0]   o_data,
  output logic [DSZ/8-1:0] o_be,
  output logic             o_full
);
  localparam int NB = DSZ / 8;
  logic [DSZ-1:0] w_mask;
  assign w_mask = DSZ'(8'hFF) << {i_lane, 3'b000};
  assign o_data = i_en ? (i_data & ~w_mask) | (DSZ'(i_byte) << {i_lane, 3'b000}) : i_data;
  assign o_be   = i_en ? i_be | (NB'(1) << i_lane) : i_be;
  assign o_full = i_en && (i_lane == 2'(NB - 1));
endmodule

// File: rtl/dict_loader.sv
// dict_loader: packs a host byte stream into memory as a dictionary image or null-terminated TIB.
// Ports: i_clk, i_rst (sync, active-low); i_start/i_mode begin a load;
//        i_s_valid/i_s_data/i_s_last/o_s_ready byte stream handshake;
//        o_mem_we/o_mem_ai/o_mem_vi/o_mem_be memory write port;
//        o_ctx/o_here dictionary pointers; o_busy/o_done/o_tib_ovf status;
//        o_cksum byte checksum, built only when DICT_LOADER_CKSUM_EN is defined.
module dict_loader
  import ejsv32_pkg::*;
#(
  parameter int          DSZ   = 8,
  parameter int          ASZ   = 17,
  parameter int unsigned DICT  = 'h0,
  parameter int unsigned TIB   = 'h0,
  parameter int unsigned TIBSZ = 256
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic             i_mode,
  input  logic             i_s_valid,
  input  logic [7:0]       i_s_data,
  input  logic             i_s_last,
  output logic             o_s_ready,
  output logic             o_mem_we,
  output logic [ASZ-1:0]   o_mem_ai,
  output logic [DSZ-1:0]   o_mem_vi,
  output logic [DSZ/8-1:0] o_mem_be,
  output logic [ASZ-1:0]   o_ctx,
  output logic [ASZ-1:0]   o_here,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_tib_ovf,
  output logic [15:0]      o_cksum
);
  localparam int NB = DSZ / 8;
  localparam logic [ASZ-1:0] DICT_A  = ASZ'(DICT);
  localparam logic [ASZ-1:0] TIB_A   = ASZ'(TIB);
  localparam logic [ASZ-1:0] TIB_END = ASZ'(TIB + TIBSZ - 1);
  localparam logic [ASZ-1:0] LANE_M  = ASZ'(NB - 1);
  loader_st_e r_st;
  logic r_mode, r_s_ready, r_mem_we, r_busy, r_done, r_tib_ovf;
  logic [ASZ-1:0] r_bp, r_mem_ai, r_ctx, r_here;
  logic [DSZ-1:0] r_pd, r_mem_vi;
  logic [NB-1:0] r_pbe, r_mem_be;
  logic w_acc, w_drop, w_keep, w_full, w_wr;
  logic [1:0] w_lane;
  logic [ASZ-1:0] w_word;
  logic [DSZ-1:0] w_pd;
  logic [NB-1:0] w_pbe;
  assign w_acc  = r_s_ready && i_s_valid;
  // The last TIB slot is reserved for the null, so bytes landing there are dropped.
  assign w_drop = (r_mode == LD_TIB) && (r_bp == TIB_END);
  assign w_keep = w_acc && !w_drop;
  assign w_lane = 2'(r_bp & LANE_M);
  assign w_word = r_bp & ~LANE_M;
  // A non-empty pack always shares bp's word, so w_word addresses the flush too.
  assign w_wr   = w_full || (i_s_last && |w_pbe);
  byte_packer #(.DSZ(DSZ)) u_packer (
    .i_data(r_pd),
    .i_be  (r_pbe),
    .i_lane(w_lane),
    .i_byte(i_s_data),
    .i_en  (w_keep),
    .o_data(w_pd),
    .o_be  (w_pbe),
    .o_full(w_full)
  );
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      r_st      <= IDLE;
      r_mode    <= LD_DICT;
      r_bp      <= '0;
      r_pd      <= '0;
      r_pbe     <= '0;
      r_s_ready <= 1'b0;
      r_mem_we  <= 1'b0;
      r_mem_ai  <= '0;
      r_mem_vi  <= '0;
      r_mem_be  <= '0;
      r_ctx     <= '0;
      r_here    <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_tib_ovf <= 1'b0;
    end else begin
      r_mem_we <= 1'b0;
      r_done   <= 1'b0;
      unique case (r_st)
        IDLE: if (i_start) begin
          r_st      <= LOAD;
          r_mode    <= i_mode;
          r_bp      <= i_mode ? TIB_A : DICT_A;
          r_pd      <= '0;
          r_pbe     <= '0;
          r_tib_ovf <= 1'b0;
          r_s_ready <= 1'b1;
          r_busy    <= 1'b1;
        end
        LOAD: if (w_acc) begin
          r_pd  <= w_wr ? '0 : w_pd;
          r_pbe <= w_wr ? '0 : w_pbe;
          if (w_keep) r_bp <= r_bp + ASZ'(1);
          if (w_drop) r_tib_ovf <= 1'b1;
          if (w_wr) begin
            r_mem_we <= 1'b1;
            r_mem_ai <= w_word;
            r_mem_vi <= w_pd;
            r_mem_be <= w_pbe;
          end
          if (i_s_last) begin
            r_st      <= FLUSH;
            r_s_ready <= 1'b0;
          end
        end
        FLUSH: if (r_mode == LD_TIB) r_st <= TERM;
        else begin
          r_ctx  <= r_bp;
          r_here <= r_bp;
          r_st   <= DONE;
        end
        TERM: begin
          r_mem_we <= 1'b1;
          r_mem_ai <= w_word;
          r_mem_vi <= '0;
          r_mem_be <= NB'(1) << w_lane;
          r_st     <= PREF;
        end
        PREF: begin
          r_mem_ai <= TIB_A;
          r_mem_be <= '0;
          r_st     <= DONE;
        end
        DONE: begin
          r_done <= 1'b1;
          r_busy <= 1'b0;
          r_st   <= IDLE;
        end
        default: r_st <= IDLE;
      endcase
    end
  end
`ifdef DICT_LOADER_CKSUM_EN
  logic [15:0] r_cksum;
  always_ff @(posedge i_clk) begin
    if (!i_rst) r_cksum <= '0;
    else if (r_st == IDLE && i_start) r_cksum <= '0;
    else if (w_acc) r_cksum <= r_cksum + 16'(i_s_data);
  end
  assign o_cksum = r_cksum;
`else
  assign o_cksum = '0;
`endif
  assign o_s_ready = r_s_ready;
  assign o_mem_we  = r_mem_we;
  assign o_mem_ai  = r_mem_ai;
  assign o_mem_vi  = r_mem_vi;
  assign o_mem_be  = r_mem_be;
  assign o_ctx     = r_ctx;
  assign o_here    = r_here;
  assign o_busy    = r_busy;
  assign o_done    = r_done;
  assign o_tib_ovf = r_tib_ovf;
endmodule

// File: tb/tb_dict_loader.sv
// tb_dict_loader: three loader configurations driven by one stream, checked against a byte-image model.
module tb_dict_loader;
  logic clk = 1'b0, rst = 1'b0, start = 1'b0, mode = 1'b0, s_valid = 1'b0, s_last = 1'b0;
  logic [7:0] s_data = 8'h00;
  logic rdy[3], we[3], busy[3], done[3], ovf[3];
  logic [16:0] ai[3], ctx[3], here[3];
  logic [15:0] ck[3];
  logic [31:0] vi0;
  logic [7:0] vi1;
  logic [15:0] vi2;
  logic [3:0] be0;
  logic [0:0] be1;
  logic [1:0] be2;
  localparam int P_DICT[3] = '{'h0, 'h20, 'h1FFFC};
  localparam int P_TIB[3]  = '{'h100, 'h100, 'h200};
  localparam int P_TSZ[3]  = '{8, 256, 4};
  int passed = 0, total = 0, fails = 0;
  int wcnt[3];
  logic [7:0] mem[int];
  logic [7:0] exp_m[int];
  logic [16:0] ectx[3];
  logic [7:0] cur[$];

  dict_loader #(.DSZ(32), .ASZ(17), .DICT('h0), .TIB('h100), .TIBSZ(8)) u0 (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_mode(mode), .i_s_valid(s_valid),
    .i_s_data(s_data), .i_s_last(s_last), .o_s_ready(rdy[0]), .o_mem_we(we[0]),
    .o_mem_ai(ai[0]), .o_mem_vi(vi0), .o_mem_be(be0), .o_ctx(ctx[0]), .o_here(here[0]),
    .o_busy(busy[0]), .o_done(done[0]), .o_tib_ovf(ovf[0]), .o_cksum(ck[0]));
  dict_loader #(.DSZ(8), .ASZ(17), .DICT('h20), .TIB('h100), .TIBSZ(256)) u1 (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_mode(mode), .i_s_valid(s_valid),
    .i_s_data(s_data), .i_s_last(s_last), .o_s_ready(rdy[1]), .o_mem_we(we[1]),
    .o_mem_ai(ai[1]), .o_mem_vi(vi1), .o_mem_be(be1), .o_ctx(ctx[1]), .o_here(here[1]),
    .o_busy(busy[1]), .o_done(done[1]), .o_tib_ovf(ovf[1]), .o_cksum(ck[1]));
  dict_loader #(.DSZ(16), .ASZ(17), .DICT('h1FFFC), .TIB('h200), .TIBSZ(4)) u2 (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_mode(mode), .i_s_valid(s_valid),
    .i_s_data(s_data), .i_s_last(s_last), .o_s_ready(rdy[2]), .o_mem_we(we[2]),
    .o_mem_ai(ai[2]), .o_mem_vi(vi2), .o_mem_be(be2), .o_ctx(ctx[2]), .o_here(here[2]),
    .o_busy(busy[2]), .o_done(done[2]), .o_tib_ovf(ovf[2]), .o_cksum(ck[2]));

  always #5 clk = ~clk;

  task automatic rec(input int d, input logic w, input logic [16:0] a, input logic [31:0] v, input logic [3:0] e);
    if (w) begin
      wcnt[d]++;
      for (int b = 0; b < 4; b++)
        if (e[b]) mem[d * 'h100000 + ((int'(a) + b) & 'h1FFFF)] = v[8*b +: 8];
    end
  endtask

  always @(negedge clk) begin
    rec(0, we[0], ai[0], vi0, be0);
    rec(1, we[1], ai[1], 32'(vi1), 4'(be1));
    rec(2, we[2], ai[2], 32'(vi2), 4'(be2));
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic do_load(input logic md, input int gmode, input bit mid);
    int n, k, w, sum;
    n = cur.size();
    sum = 0;
    mem.delete();
    exp_m.delete();
    @(posedge clk); #1;
    start = 1'b1;
    mode = md;
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 0; i < n; i++) begin
      int g;
      g = (gmode == 2) ? int'($urandom_range(0, 2)) : gmode;
      s_valid = 1'b0;
      s_last = 1'b0;
      repeat (g) begin @(posedge clk); #1; end
      s_valid = 1'b1;
      s_data = cur[i];
      s_last = (i == n - 1);
      if (mid && i == n / 2) start = 1'b1;
      w = 0;
      @(negedge clk);
      while (!rdy[0] && w < 20) begin w++; @(negedge clk); end
      if (w >= 20) begin
        chk("handshake timeout", 32'(w), 32'd0);
        break;
      end
      chk($sformatf("ready agree byte %0d", i), 32'(rdy[1] & rdy[2]), 32'd1);
      @(posedge clk); #1;
      start = 1'b0;
    end
    s_valid = 1'b0;
    s_last = 1'b0;
    k = 0;
    while (k < 20) begin
      @(negedge clk);
      k++;
      if (k == 1) chk("busy after last", 32'(busy[0]), 32'd1);
      if (md && k == 4)
        for (int d = 0; d < 3; d++) begin
          chk($sformatf("pref ai d%0d", d), 32'(ai[d]), 32'(P_TIB[d]));
          chk($sformatf("pref we d%0d", d), 32'(we[d]), 32'd0);
        end
      if (done[0]) break;
    end
    chk("done latency", 32'(k), md ? 32'd5 : 32'd3);
    chk("done agree", 32'(done[1] & done[2]), 32'd1);
    foreach (cur[i]) sum += int'(cur[i]);
    for (int d = 0; d < 3; d++) begin
      logic eovf;
      eovf = 1'b0;
      if (!md) begin
        for (int i = 0; i < n; i++) exp_m[d * 'h100000 + ((P_DICT[d] + i) & 'h1FFFF)] = cur[i];
        ectx[d] = 17'((P_DICT[d] + n) & 'h1FFFF);
      end else begin
        int kk;
        kk = (n < P_TSZ[d] - 1) ? n : P_TSZ[d] - 1;
        for (int i = 0; i < kk; i++) exp_m[d * 'h100000 + P_TIB[d] + i] = cur[i];
        exp_m[d * 'h100000 + P_TIB[d] + kk] = 8'h00;
        eovf = (n > P_TSZ[d] - 1);
      end
      chk($sformatf("ctx d%0d", d), 32'(ctx[d]), 32'(ectx[d]));
      chk($sformatf("here d%0d", d), 32'(here[d]), 32'(ectx[d]));
      chk($sformatf("tib_ovf d%0d", d), 32'(ovf[d]), 32'(eovf));
`ifdef DICT_LOADER_CKSUM_EN
      chk($sformatf("cksum d%0d", d), 32'(ck[d]), 32'(sum & 'hFFFF));
`else
      chk($sformatf("cksum d%0d", d), 32'(ck[d]), 32'd0);
`endif
    end
    chk("bytes written", 32'(mem.num()), 32'(exp_m.num()));
    foreach (exp_m[a])
      chk($sformatf("mem key %0h", a), mem.exists(a) ? 32'(mem[a]) : 32'hDEAD, 32'(exp_m[a]));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int wc;
    for (int d = 0; d < 3; d++) ectx[d] = '0;
    repeat (3) begin @(posedge clk); #1; end
    @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      chk($sformatf("rst ready d%0d", d), 32'(rdy[d]), 32'd0);
      chk($sformatf("rst we d%0d", d), 32'(we[d]), 32'd0);
      chk($sformatf("rst busy/done/ovf d%0d", d), 32'({busy[d], done[d], ovf[d]}), 32'd0);
      chk($sformatf("rst ai/ctx/here d%0d", d), 32'(ai[d] | ctx[d] | here[d]), 32'd0);
      chk($sformatf("rst cksum d%0d", d), 32'(ck[d]), 32'd0);
    end
    chk("rst vi/be d0", vi0 | 32'(be0), 32'd0);
    rst = 1'b1;
    cur = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
    do_load(1'b0, 0, 1'b0);
    cur = '{8'h31, 8'h32, 8'h33, 8'h20, 8'h34, 8'h35, 8'h36, 8'h20, 8'h2B};
    do_load(1'b1, 0, 1'b0);
    cur = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35};
    do_load(1'b1, 0, 1'b0);
    cur = '{8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hA5};
    do_load(1'b0, 1, 1'b1);
    cur = '{8'hFF, 8'hFF, 8'h02};
    do_load(1'b0, 0, 1'b0);
    wc = wcnt[0];
    @(posedge clk); #1;
    start = 1'b1;
    mode = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      s_valid = 1'b1;
      s_data = 8'hC0 + 8'(i);
      @(posedge clk); #1;
    end
    s_valid = 1'b0;
    rst = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    chk("midrst no partial write d0", 32'(wcnt[0] - wc), 32'd0);
    for (int d = 0; d < 3; d++) begin
      chk($sformatf("midrst we/ready/busy d%0d", d), 32'({we[d], rdy[d], busy[d], done[d], ovf[d]}), 32'd0);
      chk($sformatf("midrst ctx/here/ai d%0d", d), 32'(ctx[d] | here[d] | ai[d]), 32'd0);
      ectx[d] = '0;
    end
    chk("midrst vi/be d0", vi0 | 32'(be0), 32'd0);
    rst = 1'b1;
    cur = '{8'h5A, 8'h6B, 8'h7C, 8'h8D, 8'h9E, 8'hAF, 8'hB0};
    do_load(1'b0, 0, 1'b0);
    for (int it = 0; it < 12; it++) begin
      int n;
      n = int'($urandom_range(1, 14));
      cur.delete();
      for (int i = 0; i < n; i++) cur.push_back(8'($urandom));
      do_load(1'($urandom_range(0, 1)), 2, 1'($urandom_range(0, 1)));
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/dict_loader.md
# dict_loader

Synthesizable successor to the simulation-only dictionary/TIB preload path. It accepts a byte stream (from a host UART or JTAG bridge) through a valid/ready handshake and packs the bytes into words of a configurable bus width. It writes the words into the unified memory as either a dictionary image or a null-terminated TIB, then reports `ctx`/`here` and issues the TIB prefetch read for the finder. It sits between the host link and the memory bus master mux, ahead of the Forth core, which stays in reset until `done`.

## Interface
- `DSZ`, 8: memory data width; 8, 16 or 32. `NB = DSZ/8` byte lanes.
- `ASZ`, 17: byte address width (128K).
- `DICT`, 'h0: dictionary base byte address; NB-aligned.
- `TIB`, 'h0: TIB base byte address; NB-aligned.
- `TIBSZ`, 256: TIB capacity in bytes, including the terminating null.
- `clk`  in  1  clock
- `rst`  in  1  reset; synchronous, active-low
- `start`  in  1  begin a load; sampled only in IDLE
- `mode`  in  1  0 = dictionary image, 1 = TIB; latched on `start`
- `s_valid`  in  1  stream byte valid
- `s_data`  in  8  stream byte
- `s_last`  in  1  final byte of the load
- `s_ready`  out  1  loader accepts the byte this cycle
- `mem_we`  out  1  memory write strobe
- `mem_ai`  out  ASZ  memory byte address, NB-aligned
- `mem_vi`  out  DSZ  write data; little-endian lanes
- `mem_be`  out  NB  byte enables
- `ctx`, `here`  out  ASZ  dictionary context and free pointer
- `busy`, `done`  out  1  loader state flags; `done` pulses for one cycle
- `tib_ovf`  out  1  TIB bytes were dropped
- `cksum`  out  16  running byte checksum (see Configuration)

## Operation
- FSM states: IDLE → LOAD → FLUSH → (TERM → PREF, TIB only) → DONE → IDLE.
- IDLE: `s_ready`=0. On `start`, latch `mode`, set the byte pointer `bp` to DICT or TIB, clear the pack register, clear `tib_ovf`, and go to LOAD. `start` outside IDLE is ignored.
- LOAD: `s_ready`=1. Each accepted byte goes into lane `bp[log2 NB-1:0]` of the pack register, sets that lane's enable bit, and increments `bp`.
  - When the top lane fills or `s_last` is accepted, the packed word is written on the next cycle: `mem_ai = {bp_word, 0s}` with the accumulated `mem_be`.
  - Byte acceptance continues during that write, giving one byte per cycle sustained.
- The `s_last` byte moves the FSM to FLUSH. FLUSH waits for the pending write, then:
  - Dictionary mode: `ctx`, `here` ← final `bp` (DICT + byte count); go to DONE.
  - TIB mode: go to TERM.
- TERM: write a single 0x00 at `bp`, using only lane `bp mod NB` in `mem_be`.
- PREF: one cycle with `mem_we`=0 and `mem_ai`=TIB, which prefetches the TIB for the finder.
- DONE: `done`=1 for one cycle, then IDLE.
- TIB overflow: once `bp == TIB+TIBSZ-1`, further bytes are still accepted (`s_ready`=1) but discarded, and `tib_ovf` is set. The null is written at TIB+TIBSZ-1.
- Address arithmetic is modulo 2^ASZ. A dictionary image that wraps past the top of memory wraps to 0 silently.
- `ctx`/`here` change only at the end of a dictionary load. A TIB load leaves them untouched.

## Timing
- Reset values: state IDLE; `s_ready`, `mem_we`, `busy`, `done`, `tib_ovf` = 0; `mem_ai`, `mem_vi`, `mem_be`, `ctx`, `here`, `cksum` = 0.
- Write latency: the word is on the bus one cycle after the byte that completes it is accepted. All outputs are registered.
- From the `s_last` handshake to `done`:
  - Dictionary mode: 3 cycles.
  - TIB mode: 5 cycles.
- Reset asserted mid-load: the next cycle is IDLE with `mem_we`=0. The partial pack register is discarded, and `ctx`/`here` are reset.
- `s_valid`=0 gaps in LOAD are allowed and insert bubbles. A partial word stays held until completed or flushed.

## Configuration
- `DICT_LOADER_CKSUM_EN` defined: `cksum` accumulates the 16-bit sum of every accepted byte, including dropped TIB bytes. It is cleared on `start` and held after DONE.
- Not defined: `cksum` is tied to 0 and no adder is built.

## Structure
- Shared package `ejsv32_pkg`: the `loader_st_e` enum (IDLE, LOAD, FLUSH, TERM, PREF, DONE) and the `LD_DICT`/`LD_TIB` mode constants.
- One sub-module, `byte_packer`: lane insert, byte-enable accumulation and flush/full detect. It is parametrised by DSZ.

## Test plan
- DSZ=32, DICT=0, bytes 11 22 33 44 55 (`s_last` on 55) → write @0 44332211/be F, then @4 00000055/be 1; `ctx`=`here`=5; `done` 3 cycles after the last byte.
- DSZ=8, TIB='h100, mode 1, "123 456 +" → 9 writes at 0x100–0x108, 0x00 at 0x109, then one PREF cycle with `ai`=0x100 and `we`=0, then `done`; `ctx`/`here` unchanged.
- TIBSZ=4, "12345" → writes '1','2','3' and null at TIB+3; `tib_ovf`=1; all 5 bytes handshaken.
- DSZ=16, `s_valid` toggling every other cycle over 6 bytes → 3 full-BE writes, correct data; `start` pulsed mid-load is ignored.
- Reset driven low during LOAD after 3 bytes (DSZ=32) → no write of the partial word; all outputs at reset values next cycle; a fresh load then succeeds.
- With `DICT_LOADER_CKSUM_EN`: bytes FF FF 02 → `cksum`=0x0200; without the macro → `cksum`=0.
